// File: rtl/wbdbgbus_cmd_exec.sv
// Debug-bus command executor: takes {opcode, payload} commands, runs single pipelined
// Wishbone B4 read/write cycles and emits one {resp_code, payload} response per command.
module wbdbgbus_cmd_exec #(
  parameter int unsigned BUS_TIMEOUT = 1024,
  parameter int unsigned ADDR_STEP   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [35:0] i_cmd_data,
  output logic        o_resp_valid,
  output logic [35:0] o_resp_data,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data
);

  localparam int unsigned       TimerW    = $clog2(BUS_TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(BUS_TIMEOUT - 1);

  localparam logic [3:0] OpSetAddr  = 4'h1;
  localparam logic [3:0] OpSetInc   = 4'h2;
  localparam logic [3:0] OpRead     = 4'h3;
  localparam logic [3:0] OpWrite    = 4'h4;
  localparam logic [3:0] RspRead    = 4'h0;
  localparam logic [3:0] RspWrite   = 4'h1;
  localparam logic [3:0] RspAddr    = 4'h2;
  localparam logic [3:0] RspInc     = 4'h3;
  localparam logic [3:0] RspErr     = 4'h4;
  localparam logic [3:0] RspEcho    = 4'h5;
  localparam logic [3:0] RspTimeout = 4'h6;

  typedef enum logic [1:0] {StIdle, StStrobe, StWaitAck, StResp} state_e;

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic                inc_q, inc_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0]         wb_addr_q, wb_addr_d, wb_data_q, wb_data_d;
  logic [35:0]         pend_q, pend_d, resp_data_q, resp_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic                adv_q, adv_d;
  logic [3:0]          op;
  logic [31:0]         payload;

  assign op      = i_cmd_data[35:32];
  assign payload = i_cmd_data[31:0];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    inc_d        = inc_q;
    timer_d      = timer_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    pend_d       = pend_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    adv_d        = adv_q;

    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          adv_d   = 1'b0;
          state_d = StResp;
          case (op)
            OpSetAddr: begin
              addr_d = payload;
              pend_d = {RspAddr, payload};
            end
            OpSetInc: begin
              inc_d  = payload[0];
              pend_d = {RspInc, 31'b0, payload[0]};
            end
            OpRead, OpWrite: begin
              cyc_d     = 1'b1;
              stb_d     = 1'b1;
              we_d      = (op == OpWrite);
              wb_addr_d = addr_q;
              if (op == OpWrite) wb_data_d = payload;
              timer_d   = '0;
              state_d   = StStrobe;
            end
            default: pend_d = {RspEcho, payload};
          endcase
        end
      end
      StStrobe, StWaitAck: begin
        timer_d = timer_q + TimerW'(1);
        if (state_q == StStrobe && !i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = StWaitAck;
        end
        // A bus answer in the final timer cycle still beats the timeout.
        if (i_wb_ack || i_wb_err) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StResp;
          if (i_wb_err) begin
            pend_d = {RspErr, addr_q};
          end else begin
            pend_d = we_q ? {RspWrite, 32'h0} : {RspRead, i_wb_data};
            adv_d  = inc_q;
          end
        end else if (timer_q == TimerLast) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StResp;
          pend_d  = {RspTimeout, addr_q};
        end
      end
      StResp: begin
        resp_valid_d = 1'b1;
        resp_data_d  = pend_q;
        if (adv_q) addr_d = addr_q + 32'(ADDR_STEP);
        adv_d        = 1'b0;
        state_d      = StIdle;
      end
    endcase

    // Soft reset kills any live cycle and drops the pending response.
    if (i_cmd_reset) begin
      state_d      = StIdle;
      addr_d       = '0;
      inc_d        = 1'b1;
      timer_d      = '0;
      cyc_d        = 1'b0;
      stb_d        = 1'b0;
      we_d         = 1'b0;
      wb_addr_d    = '0;
      wb_data_d    = '0;
      pend_d       = '0;
      resp_data_d  = '0;
      resp_valid_d = 1'b0;
      adv_d        = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      inc_q        <= 1'b1;
      timer_q      <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      pend_q       <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      adv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inc_q        <= inc_d;
      timer_q      <= timer_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      pend_q       <= pend_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      adv_q        <= adv_d;
    end
  end

  assign o_cmd_ready  = (state_q == StIdle);
  assign o_resp_valid = resp_valid_q;
  assign o_resp_data  = resp_data_q;
  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_we      = we_q;
  assign o_wb_addr    = wb_addr_q;
  assign o_wb_data    = wb_data_q;

endmodule

// File: tb/tb_wbdbgbus_cmd_exec.sv
// Bench for wbdbgbus_cmd_exec: transaction-level model predicts per-cycle bus/handshake
// windows and responses for directed and random commands against a scripted Wishbone slave.
module tb_wbdbgbus_cmd_exec;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0, rst_n = 1'b0, cmd_reset = 1'b0, cmd_valid = 1'b0, cmd_ready;
  logic [35:0] cmd_data = '0, resp_data;
  logic        resp_valid, wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdata, wb_rdata = '0;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_stall = 1'b0;

  always #5 clk = ~clk;

  wbdbgbus_cmd_exec #(.BUS_TIMEOUT(TO), .ADDR_STEP(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_reset(cmd_reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_data(cmd_data),
    .o_resp_valid(resp_valid), .o_resp_data(resp_data),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_stall(wb_stall), .i_wb_data(wb_rdata)
  );

  // kind: 0 ack, 1 err, 2 no answer (timeout)
  typedef struct {
    logic [35:0] cmd;
    int          kind;
    int          s;
    int          d;
    logic [31:0] rdata;
    int          rst_after;
  } cmd_t;

  cmd_t        cq[$];
  cmd_t        cur;
  bit          offering = 0;
  int unsigned npass = 0, ntotal = 0;
  int          n = 0, soft_at = -1;

  // Architectural model state and the one outstanding transaction
  logic [31:0] m_addr = '0;
  logic        m_inc = 1'b1;
  int          t_a = -100, t_r = 0, t_endc = 0, t_stbend = 0, t_cack = -1, t_kind = 0;
  bit          t_bus = 0, t_rsp = 0, t_we = 0;
  logic [31:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
  logic [35:0] t_resp = '0;

  bit          chk_en = 0;
  bit          e_ready = 1, e_cyc = 0, e_stb = 0, e_we = 0, e_rv = 0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [35:0] e_resp = '0;
  int          e_lat = 0;
  logic [35:0] rlog[$];
  int          llog[$];

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
  endtask

  task automatic add(input logic [35:0] c, input int kind, input int s, input int d,
                     input logic [31:0] rd, input int ra);
    cmd_t e;
    e.cmd = c; e.kind = kind; e.s = s; e.d = d; e.rdata = rd; e.rst_after = ra;
    cq.push_back(e);
  endtask

  task automatic accept(input cmd_t c);
    logic [3:0]  op;
    logic [31:0] pl;
    op = c.cmd[35:32];
    pl = c.cmd[31:0];
    t_a = n; t_rsp = 1; t_bus = 0; t_kind = c.kind; t_cack = -1;
    if (c.rst_after > 0) soft_at = n + c.rst_after;
    case (op)
      4'h1: begin m_addr = pl; t_resp = {4'h2, pl}; end
      4'h2: begin m_inc = pl[0]; t_resp = {4'h3, 31'b0, pl[0]}; end
      4'h3, 4'h4: begin
        t_bus = 1; t_we = (op == 4'h4); t_addr = m_addr; t_wdata = pl; t_rdata = c.rdata;
        t_stbend = n + 1 + c.s;
        if (c.kind == 2) begin
          t_endc = n + TO;
          t_resp = {4'h6, m_addr};
        end else begin
          t_cack = n + 1 + c.s + c.d;
          t_endc = t_cack;
          if (c.kind == 1) t_resp = {4'h4, m_addr};
          else begin
            t_resp = t_we ? {4'h1, 32'h0} : {4'h0, c.rdata};
            if (m_inc) m_addr = m_addr + 32'd4;
          end
        end
      end
      default: t_resp = {4'h5, pl};
    endcase
    t_r = t_bus ? t_endc + 2 : n + 2;
  endtask

  // One clock: set expectations for the new cycle, then drive slave and command inputs.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    chk_en  = 1;
    e_ready = (n >= t_r);
    e_cyc   = t_bus && n > t_a && n <= t_endc;
    e_stb   = t_bus && n > t_a && n <= t_stbend;
    e_we    = e_cyc && t_we;
    e_addr  = t_addr;
    e_wdata = t_wdata;
    e_rv    = t_rsp && n == t_r;
    e_resp  = t_resp;
    e_lat   = n - t_a;
    wb_stall = t_bus && n > t_a && n < t_stbend;
    wb_ack   = t_bus && t_kind == 0 && n == t_cack;
    wb_err   = t_bus && t_kind == 1 && n == t_cack;
    wb_rdata = wb_ack ? t_rdata : $urandom;
    cmd_reset = (n == soft_at);
    if (cmd_reset) begin
      m_addr = '0; m_inc = 1'b1; t_bus = 0; t_rsp = 0; t_r = n + 1;
    end
    if (!offering && cq.size() > 0 && $urandom_range(0, 2) != 0) begin
      cur = cq.pop_front();
      offering = 1;
    end
    cmd_valid = offering && !cmd_reset;
    cmd_data  = offering ? cur.cmd : {4'($urandom), 32'($urandom)};
    if (cmd_valid && n >= t_r) begin
      accept(cur);
      offering = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", {35'b0, cmd_ready}, {35'b0, e_ready});
      check("wb_cyc", {35'b0, wb_cyc}, {35'b0, e_cyc});
      check("wb_stb", {35'b0, wb_stb}, {35'b0, e_stb});
      check("resp_valid", {35'b0, resp_valid}, {35'b0, e_rv});
      if (e_stb) begin
        check("wb_addr", {4'b0, wb_addr}, {4'b0, e_addr});
        check("wb_we", {35'b0, wb_we}, {35'b0, e_we});
        if (e_we) check("wb_wdata", {4'b0, wb_wdata}, {4'b0, e_wdata});
      end
      if (e_rv) check("resp_data", resp_data, e_resp);
      if (resp_valid) begin
        rlog.push_back(resp_data);
        llog.push_back(e_lat);
      end
    end
  end

  initial begin
    logic [35:0] lit [15];
    int          r, k;
    logic [3:0]  op;
    logic [31:0] pl;

    #2;
    check("rst_ready", {35'b0, cmd_ready}, 36'h1);
    check("rst_cyc_stb_we", {33'b0, wb_cyc, wb_stb, wb_we}, 36'h0);
    check("rst_addr", {4'b0, wb_addr}, 36'h0);
    check("rst_wdata", {4'b0, wb_wdata}, 36'h0);
    check("rst_resp", {resp_valid, resp_data[34:0]}, 36'h0);

    add({4'h1, 32'h1000_0000}, 0, 0, 0, 0, 0);          // 0
    add({4'h4, 32'hDEAD_BEEF}, 0, 2, 1, 0, 0);          // 1
    add({4'h3, 32'h0}, 0, 0, 0, 32'hCAFE_F00D, 0);      // 2
    add({4'h2, 32'h0}, 0, 0, 0, 0, 0);                  // 3
    add({4'h3, 32'h0}, 0, 1, 2, 32'h1111_1111, 0);      // 4
    add({4'h3, 32'h0}, 1, 0, 0, 0, 0);                  // 5
    add({4'h3, 32'h0}, 2, 3, 0, 0, 0);                  // 6
    add({4'h7, 32'h1234_5678}, 0, 0, 0, 0, 0);          // 7
    add({4'h2, 32'h1}, 0, 0, 0, 0, 0);                  // 8
    add({4'h1, 32'hFFFF_FFFC}, 0, 0, 0, 0, 0);          // 9
    add({4'h3, 32'h0}, 0, 0, 0, 32'hA5A5_A5A5, 0);      // 10
    add({4'h3, 32'h0}, 1, 0, 0, 0, 0);                  // 11
    add({4'h3, 32'h0}, 2, 2, 0, 0, 8);                  // soft reset in WAIT_ACK, no resp
    add({4'h3, 32'h0}, 1, 0, 0, 0, 0);                  // 12
    add({4'h3, 32'h0}, 0, 0, 0, 32'h0BAD_F00D, 0);      // 13
    add({4'h3, 32'h0}, 1, 1, 1, 0, 0);                  // 14
    lit = '{36'h2_1000_0000, 36'h1_0000_0000, 36'h0_CAFE_F00D, 36'h3_0000_0000,
            36'h0_1111_1111, 36'h4_1000_0008, 36'h6_1000_0008, 36'h5_1234_5678,
            36'h3_0000_0001, 36'h2_FFFF_FFFC, 36'h0_A5A5_A5A5, 36'h4_0000_0000,
            36'h4_0000_0000, 36'h0_0BAD_F00D, 36'h4_0000_0004};

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      pl = $urandom;
      if (r < 2) begin
        op = 4'h1;
        if ($urandom_range(0, 3) == 0) pl = 32'hFFFF_FFF8;
      end else if (r == 2) op = 4'h2;
      else if (r < 6) op = 4'h3;
      else if (r < 8) op = 4'h4;
      else begin
        op = 4'($urandom_range(5, 15));
        if ($urandom_range(0, 3) == 0) op = 4'h0;
      end
      k = $urandom_range(0, 9);
      add({op, pl}, (k < 7) ? 0 : (k < 9) ? 1 : 2, $urandom_range(0, 3), $urandom_range(0, 4),
          $urandom, 0);
    end

    @(posedge clk);
    #1 rst_n = 1'b1;
    while ((cq.size() > 0 || offering || n < t_r + 2) && n < 20000) step();
    check("drained", {35'b0, (cq.size() == 0 && !offering)}, 36'h1);

    check("resp_count_min", {35'b0, (rlog.size() >= 15)}, 36'h1);
    if (rlog.size() >= 15) begin
      for (int i = 0; i < 15; i++) check($sformatf("directed_resp%0d", i), rlog[i], lit[i]);
      check("lat_set_addr", 36'(llog[0]), 36'd2);
      check("lat_write_stall", 36'(llog[1]), 36'd6);
      check("lat_read_fast", 36'(llog[2]), 36'd3);
      check("lat_timeout", 36'(llog[6]), 36'd18);
    end

    // Asynchronous reset while a strobe is stalled
    chk_en = 0;
    @(posedge clk);
    #1;
    cmd_data = {4'h4, 32'h5555_AAAA}; cmd_valid = 1'b1; wb_stall = 1'b1;
    wb_ack = 1'b0; wb_err = 1'b0; cmd_reset = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("async_pre_stb", {35'b0, wb_stb}, 36'h1);
    check("async_pre_wdata", {4'b0, wb_wdata}, 36'h0_5555_AAAA);
    #2 rst_n = 1'b0;
    #1;
    check("async_cyc_stb_we", {33'b0, wb_cyc, wb_stb, wb_we}, 36'h0);
    check("async_addr", {4'b0, wb_addr}, 36'h0);
    check("async_wdata", {4'b0, wb_wdata}, 36'h0);
    check("async_resp", {resp_valid, resp_data[34:0]}, 36'h0);
    check("async_ready", {35'b0, cmd_ready}, 36'h1);
    wb_stall = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
